// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and control encodings shared by the decode stage and the ALU.
package alu_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } alu_op_t;
  typedef struct packed {
    alu_ctrl_t   alu_control;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    result_src_t result_src;
    logic        branch;
    logic        jump;
    logic        valid;
  } ctrl_t;
  function automatic logic funct3_ok(input logic [2:0] f);
    return f == 3'b000 || f == 3'b010 || f == 3'b110 || f == 3'b111;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp, funct3, funct7[5] and opcode[5] to the ALU operation.
module alu_decoder
  import alu_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        op5,
  output alu_ctrl_t   alu_control
);
  // sub only for R-type (op5=1); I-type funct3=000 is always addi
  assign alu_control = (alu_op == AOP_SUB)   ? ALU_SUB :
                       (alu_op != AOP_FUNCT) ? ALU_ADD :
                       (funct3 == 3'b000)    ? ((op5 && funct7_5) ? ALU_SUB : ALU_ADD) :
                       (funct3 == 3'b010)    ? ALU_SLT :
                       (funct3 == 3'b110)    ? ALU_OR  :
                       (funct3 == 3'b111)    ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: main decoder and D->E control register; ALU_CTRL_ILLEGAL_EN enables the IllegalE flag.
module alu_ctrl_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [1:0]  ImmSrcD,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ValidE,
  output logic        IllegalE
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       known, ok, unused_bits;
  alu_op_t    alu_op;
  alu_ctrl_t  alu_control;
  imm_src_t   imm_raw;
  ctrl_t      m, d, e;
  assign opcode      = InstrD[6:0];
  assign funct3      = InstrD[14:12];
  assign unused_bits = ^{InstrD[31], InstrD[29:15], InstrD[11:7]};
  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (InstrD[30]),
    .op5         (InstrD[5]),
    .alu_control (alu_control)
  );
  always_comb begin
    m       = '0;
    alu_op  = AOP_ADD;
    imm_raw = IMM_I;
    known   = 1'b1;
    case (opcode)
      OP_LW: begin
        m.alu_src    = 1'b1;
        m.reg_write  = 1'b1;
        m.result_src = RES_MEM;
      end
      OP_SW: begin
        m.alu_src   = 1'b1;
        m.mem_write = 1'b1;
        imm_raw     = IMM_S;
      end
      OP_BEQ: begin
        m.branch = 1'b1;
        alu_op   = AOP_SUB;
        imm_raw  = IMM_B;
      end
      OP_R: begin
        m.reg_write = 1'b1;
        alu_op      = AOP_FUNCT;
        known       = funct3_ok(funct3);
      end
      OP_I: begin
        m.alu_src   = 1'b1;
        m.reg_write = 1'b1;
        alu_op      = AOP_FUNCT;
        known       = funct3_ok(funct3);
      end
      OP_JAL: begin
        m.jump       = 1'b1;
        m.reg_write  = 1'b1;
        m.result_src = RES_PC4;
        imm_raw      = IMM_J;
      end
      default: known = 1'b0;
    endcase
  end
  // invalid slots and illegal encodings both decode to all-zero controls
  assign ok      = ValidD && known;
  assign ImmSrcD = ok ? imm_raw : IMM_I;
  always_comb begin
    d             = ok ? m : '0;
    d.alu_control = ok ? alu_control : ALU_ADD;
    d.valid       = ValidD;
  end
  always_ff @(posedge clk) begin
    if (rst || FlushE) e <= '0;
    else if (!StallE) e <= d;
  end
`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst || FlushE) illegal_q <= 1'b0;
    else if (!StallE) illegal_q <= ValidD && !known;
  end
  assign IllegalE = illegal_q;
`else
  assign IllegalE = 1'b0;
`endif
  assign ALUControlE = e.alu_control;
  assign ALUSrcE     = e.alu_src;
  assign RegWriteE   = e.reg_write;
  assign MemWriteE   = e.mem_write;
  assign ResultSrcE  = e.result_src;
  assign BranchE     = e.branch;
  assign JumpE       = e.jump;
  assign ValidE      = e.valid;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed vector table plus randomized run against a spec-level decode model.
module tb_alu_ctrl_stage;
`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif
  // {alu[2:0], src, rw, mw, res[1:0], br, j, v, ill}
  typedef struct packed {
    logic [2:0] alu;
    logic       src, rw, mw;
    logic [1:0] res;
    logic       br, j, v, ill;
  } out_t;
  typedef struct {
    logic        r, v, s, f;
    logic [31:0] instr;
    logic [1:0]  imm;
    out_t        exp;
  } vec_t;
  logic        clk, rst, ValidD, StallE, FlushE;
  logic [31:0] InstrD;
  logic [1:0]  ImmSrcD, ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE;
  out_t        act;
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  alu_ctrl_stage dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .ImmSrcD     (ImmSrcD),
    .ALUControlE (ALUControlE),
    .ALUSrcE     (ALUSrcE),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .ValidE      (ValidE),
    .IllegalE    (IllegalE)
  );
  assign act = {ALUControlE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ValidE, IllegalE};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void ref_dec(input logic [31:0] i, input logic v, output out_t o, output logic [1:0] imm);
    logic ok;
    o   = '0;
    imm = 2'b00;
    ok  = 1'b1;
    case (i[6:0])
      7'h03: begin o.src = 1'b1; o.rw = 1'b1; o.res = 2'b01; end
      7'h23: begin o.src = 1'b1; o.mw = 1'b1; imm = 2'b01; end
      7'h63: begin o.alu = 3'b001; o.br = 1'b1; imm = 2'b10; end
      7'h33, 7'h13: begin
        o.rw  = 1'b1;
        o.src = (i[6:0] == 7'h13);
        case (i[14:12])
          3'b000:  o.alu = (i[6:0] == 7'h33 && i[30]) ? 3'b001 : 3'b000;
          3'b010:  o.alu = 3'b101;
          3'b110:  o.alu = 3'b011;
          3'b111:  o.alu = 3'b010;
          default: ok = 1'b0;
        endcase
      end
      7'h6F: begin o.rw = 1'b1; o.j = 1'b1; o.res = 2'b10; imm = 2'b11; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      o     = '0;
      imm   = 2'b00;
      o.ill = ILL;
    end
    o.v = 1'b1;
    if (!v) begin
      o   = '0;
      imm = 2'b00;
    end
  endfunction
  task automatic push(input logic r, v, s, f, input logic [31:0] i, input logic [1:0] imm, input out_t e);
    vecs.push_back('{r, v, s, f, i, imm, e});
  endtask
  task automatic drive(input logic r, v, s, f, input logic [31:0] i);
    rst    = r;
    ValidD = v;
    StallE = s;
    FlushE = f;
    InstrD = i;
  endtask
  task automatic check_imm(input string name, input logic [1:0] want);
    checks++;
    if (ImmSrcD !== want) begin
      errors++;
      $display("FAIL %s ImmSrcD got %b want %b", name, ImmSrcD, want);
    end
  endtask
  task automatic check_out(input string name, input out_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s E-stage got %b want %b (alu,src,rw,mw,res,br,j,v,ill)", name, act, want);
    end
  endtask
  initial begin
    out_t       exp_q, o, nxt;
    logic [1:0] imm;
    logic       r, v, s, f;
    logic [31:0] i;
    logic [6:0] ops[7] = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h6F, 7'h00};
    push(1, 1, 0, 0, 32'h002081B3, 2'b00, 12'b000_000_00_0000);
    push(0, 1, 0, 0, 32'h002081B3, 2'b00, 12'b000_010_00_0010);
    push(0, 1, 0, 0, 32'h402081B3, 2'b00, 12'b001_010_00_0010);
    push(0, 1, 0, 0, 32'h0050A193, 2'b00, 12'b101_110_00_0010);
    push(0, 1, 0, 0, 32'h00208463, 2'b10, 12'b001_000_00_1010);
    push(0, 1, 0, 0, 32'h0000A183, 2'b00, 12'b000_110_01_0010);
    push(0, 1, 0, 0, 32'h0020A223, 2'b01, 12'b000_101_00_0010);
    push(0, 1, 0, 0, 32'h008000EF, 2'b11, 12'b000_010_10_0110);
    push(1, 1, 0, 0, 32'h002081B3, 2'b00, 12'b000_000_00_0000);
    push(0, 1, 0, 0, 32'h002081B3, 2'b00, 12'b000_010_00_0010);
    push(0, 0, 0, 0, 32'h002081B3, 2'b00, 12'b000_000_00_0000);
    push(0, 1, 0, 0, 32'h002081B3, 2'b00, 12'b000_010_00_0010);
    push(0, 1, 1, 0, 32'h402081B3, 2'b00, 12'b000_010_00_0010);
    push(0, 1, 1, 0, 32'h402081B3, 2'b00, 12'b000_010_00_0010);
    push(0, 1, 1, 1, 32'h402081B3, 2'b00, 12'b000_000_00_0000);
    push(0, 1, 0, 0, 32'h0020C1B3, 2'b00, {11'b000_000_00_001, ILL});
    push(0, 1, 0, 0, 32'h0030E193, 2'b00, 12'b011_110_00_0010);
    push(0, 1, 0, 0, 32'h40008193, 2'b00, 12'b000_110_00_0010);
    push(0, 1, 0, 0, 32'h0020F1B3, 2'b00, 12'b010_010_00_0010);
    push(0, 1, 0, 0, 32'h0000007F, 2'b00, {11'b000_000_00_001, ILL});
    push(0, 1, 0, 1, 32'h008000EF, 2'b11, 12'b000_000_00_0000);
    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].v, vecs[k].s, vecs[k].f, vecs[k].instr);
      #1 check_imm($sformatf("vec%0d_imm", k), vecs[k].imm);
      @(posedge clk);
      #1 check_out($sformatf("vec%0d_out", k), vecs[k].exp);
    end
    exp_q = vecs[vecs.size() - 1].exp;
    for (int n = 0; n < 400; n++) begin
      i = $urandom;
      i[6:0] = ops[$urandom_range(6)];
      if ($urandom_range(9) == 0) i = $urandom;
      v = ($urandom_range(99) < 85);
      s = ($urandom_range(99) < 20);
      f = ($urandom_range(99) < 10);
      r = ($urandom_range(99) < 3);
      ref_dec(i, v, o, imm);
      nxt = (r || f) ? out_t'('0) : s ? exp_q : o;
      drive(r, v, s, f, i);
      #1 check_imm($sformatf("rand%0d_imm", n), imm);
      @(posedge clk);
      #1 check_out($sformatf("rand%0d_out", n), nxt);
      exp_q = nxt;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port InstrD, input, 32, instruction in decode stage.
REQ-004 SHALL have port ValidD, input, 1, InstrD holds a real instruction.
REQ-005 SHALL have port StallE, input, 1, hold E-stage register contents.
REQ-006 SHALL have port FlushE, input, 1, load a bubble into the E-stage register.
REQ-007 SHALL have port ImmSrcD, output, 2, combinational immediate format: 00=I, 01=S, 10=B, 11=J.
REQ-008 SHALL have port ALUControlE, output, 3, registered ALU operation: 000=add, 001=sub, 010=and, 011=or, 101=slt.
REQ-009 SHALL have registered E-stage outputs ALUSrcE (1), RegWriteE (1), MemWriteE (1), ResultSrcE (2; 00=ALU, 01=mem, 10=PC+4), BranchE (1), JumpE (1), ValidE (1) and IllegalE (1).

Function
REQ-010 SHALL decode opcode 0000011 (lw) as add, ALUSrc=1, RegWrite=1, ResultSrc=01, ImmSrc=00.
REQ-011 SHALL decode opcode 0100011 (sw) as add, ALUSrc=1, MemWrite=1, ImmSrc=01.
REQ-012 SHALL decode opcode 1100011 (beq) as sub, Branch=1, ImmSrc=10.
REQ-013 SHALL decode opcode 0110011 (R-type), RegWrite=1, ALUSrc=0, with this funct3 mapping: 000 gives sub when funct7[5]=1, else add; 010 gives slt; 110 gives or; 111 gives and.
REQ-014 SHALL decode opcode 0010011 (I-type ALU) with the same funct3 map as REQ-013, except that funct3=000 always gives add; ALUSrc=1, RegWrite=1.
REQ-015 SHALL decode opcode 1101111 (jal) as add, Jump=1, RegWrite=1, ResultSrc=10, ImmSrc=11.
REQ-016 SHALL treat any other opcode or funct3 as illegal: all control outputs 0, ALUControl=000.
REQ-017 SHALL force all decoded control outputs to 0 when ValidD=0.
REQ-018 SHALL give each E-stage output exactly one cycle of latency from the D-stage decode.
REQ-019 SHALL update the E-stage register with priority rst > FlushE > StallE > load.
REQ-020 SHALL, on FlushE=1, load all zeros (bubble, ValidE=0), including when StallE=1 in the same cycle.
REQ-021 SHALL, on StallE=1 with FlushE=0, hold every E-stage output unchanged; the incoming InstrD is not captured.
REQ-022 SHALL produce ImmSrcD combinationally, unaffected by StallE and FlushE.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set every registered output to 0 (ALUControlE=000, ResultSrcE=00, ValidE=0, IllegalE=0).
REQ-024 SHALL discard any in-flight instruction when reset is asserted mid-stream; the first capture occurs on the first edge with rst=0.

Configuration
REQ-025 SHALL support macro ALU_CTRL_ILLEGAL_EN: when defined, IllegalE is registered as 1 for a valid illegal instruction per REQ-016, with all other controls 0.
REQ-026 SHALL, when ALU_CTRL_ILLEGAL_EN is undefined, keep the IllegalE port present and tie it to constant 0; all other behaviour is unchanged.

Structure
REQ-027 SHALL place opcode constants, ALUControl encodings, ResultSrc encodings and ImmSrc encodings in the shared package alu_pkg, also used by alu.
REQ-028 SHALL instantiate one combinational sub-module, alu_decoder, that maps (ALUOp, funct3, funct7[5], opcode[5]) to ALUControl; the main decoder and the E-stage register stay in the top module.

Verification
REQ-029 SHALL cover: InstrD=0x002081B3 (add) with ValidD=1 -> next cycle ALUControlE=000, RegWriteE=1, ALUSrcE=0, ValidE=1.
REQ-030 SHALL cover: 0x402081B3 (sub) -> ALUControlE=001; then 0x0050A193 (slti) -> ALUControlE=101, ALUSrcE=1, ImmSrcD=00 combinationally.
REQ-031 SHALL cover: 0x00208463 (beq) -> ALUControlE=001, BranchE=1, RegWriteE=0, ImmSrcD=10; then 0x0000A183 (lw) -> ALUControlE=000, ResultSrcE=01.
REQ-032 SHALL cover: load add, then StallE=1 with InstrD=sub for 2 cycles -> ALUControlE stays 000; then StallE=1 with FlushE=1 -> all outputs 0.
REQ-033 SHALL cover: 0x0020C1B3 (xor) -> with ALU_CTRL_ILLEGAL_EN, IllegalE=1, RegWriteE=0, ALUControlE=000; without the macro, IllegalE=0.
REQ-034 SHALL cover: rst=1 asserted while a valid jal sits in the E stage -> next cycle all outputs 0; after rst falls, the first capture occurs on the next edge.
